calc_entry_sequencer: RTL and testbench
=======================================

Name: calc_entry_sequencer

Overview:
Keypad-entry front end for the calculator. It consumes raw key strobes and key codes, builds multi-digit BCD operands, and latches the pending operator. It issues a one-cycle execute strobe with both operands and the operator held stable for the ALU. It sits between the keypad interface and the arithmetic/display datapath, and supports result chaining, repeat-equals, backspace and clear.

Parameters:
NUM_DIGITS, 4, maximum BCD digits per operand (≥1)
W (derived), NUM_DIGITS*4, operand width in bits
CW (derived), $clog2(NUM_DIGITS+1), digit-count width

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
new_key  in  1  one-cycle strobe; key_code valid when high
key_code  in  5  [4]=1 digit (value in [3:0]); [4]=0 function key
result_in  in  W  BCD result from ALU, used for chaining
entry_bcd  out  W  operand currently being typed (display source)
entry_count  out  CW  digits currently in entry_bcd
operand_a  out  W  latched first operand
operand_b  out  W  latched second operand
op_code  out  4  latched operator (key_code[3:0] of the op key)
execute  out  1  one-cycle strobe: operand_a/operand_b/op_code are valid
key_error  out  1  one-cycle strobe: key rejected
state  out  2  00 ENTER_A, 01 ENTER_B, 10 DONE

Behaviour:
- Key decode, only when new_key=1:
  - digit: key_code[4]=1 and [3:0]≤9
  - bad digit: key_code[4]=1 and [3:0]≥10
  - EQUAL: 5'b00001
  - BACKSPACE: 5'b01110
  - CLEAR: 5'b01111
  - OP: any other code with [4]=0, including 5'b00000
- All outputs are registered. Response appears one clock after the new_key cycle. With new_key=0, nothing changes and execute/key_error are 0.
- Reset: state=ENTER_A; entry_bcd, operand_a, operand_b, op_code=0; entry_count=0; execute=key_error=0.
- Reset has priority over any key in the same cycle. Reset mid-entry discards everything.
- Digit entry (ENTER_A/ENTER_B):
  - entry_bcd <= {entry_bcd[W-5:0], digit}; entry_count+1.
  - Leading zero: if entry_count=0 and digit=0, entry_bcd stays 0, count stays 0, no error.
  - Full: entry_count=NUM_DIGITS → digit ignored, key_error=1.
- Bad digit: ignored in any state, key_error=1.
- BACKSPACE (ENTER_A/ENTER_B):
  - entry_bcd <= {4'h0, entry_bcd[W-1:4]}; count-1.
  - count=0 → no change, no error.
  - In DONE → ignored, no error.
- CLEAR, any state: same effect as reset, except key_error=0.
- ENTER_A:
  - OP: operand_a<=entry_bcd, op_code<=key_code[3:0], clear entry, → ENTER_B.
  - EQUAL: ignored, key_error=1.
- ENTER_B:
  - OP with count=0: op_code replaced, stay.
  - OP with count>0: ignored, key_error=1 (no implicit chaining mid-entry).
  - EQUAL: operand_b<=entry_bcd (0 if count=0), execute=1, entry cleared, → DONE.
- DONE:
  - digit: entry starts fresh with that digit (leading-zero rule applies), operand_a/operand_b/op_code hold, → ENTER_A.
  - OP: operand_a<=result_in (sampled in the key cycle), op_code<=key_code[3:0], → ENTER_B.
  - EQUAL: repeat; execute=1 again with operand_a, operand_b, op_code unchanged, stay DONE.
- execute and key_error never assert in the same cycle and never exceed one cycle per key.
- No arithmetic is performed inside this block. BCD digits are stored verbatim.

Test Plan:
- NUM_DIGITS=4; reset; keys 1,2,3 → entry_bcd=16'h0123, entry_count=3, state=ENTER_A; then 4,5 → entry_bcd=16'h1234, count=4, key_error pulses on the 5.
- Keys 0,0,7 → entry_bcd=16'h0007, count=1; BACKSPACE ×2 → entry_bcd=0, count=0, no key_error.
- Keys 4, OP(5'b00010), 9, EQUAL → operand_a=16'h0004, op_code=4'h2, operand_b=16'h0009, single-cycle execute one clock after EQUAL, state=DONE; EQUAL again → second execute pulse with identical operands.
- In DONE with result_in=16'h0013: OP(5'b00011), 2, EQUAL → operand_a=16'h0013, op_code=4'h3, operand_b=16'h0002, execute pulses.
- EQUAL in ENTER_A → key_error pulse, state unchanged. Key_code 5'b11010 → key_error pulse, entry unchanged. OP pressed twice in ENTER_B with count=0 → op_code holds the second code.
- Mid-entry 12 OP 3, assert reset together with new_key digit 7 → all outputs 0, state=ENTER_A, digit 7 not captured. CLEAR gives the same result with key_error=0.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// Keypad-entry front end: builds BCD operands from key strobes, latches the operator
// and issues a one-cycle execute strobe to the ALU, with chaining and repeat-equals.
module calc_entry_sequencer #(
    parameter int unsigned NUM_DIGITS = 4,
    localparam int unsigned W  = NUM_DIGITS * 4,
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          new_key,
    input  logic [4:0]    key_code,
    input  logic [W-1:0]  result_in,
    output logic [W-1:0]  entry_bcd,
    output logic [CW-1:0] entry_count,
    output logic [W-1:0]  operand_a,
    output logic [W-1:0]  operand_b,
    output logic [3:0]    op_code,
    output logic          execute,
    output logic          key_error,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        StEnterA = 2'b00,
        StEnterB = 2'b01,
        StDone   = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        KeyNone,
        KeyDigit,
        KeyBadDigit,
        KeyEqual,
        KeyBack,
        KeyClear,
        KeyOp
    } key_e;

    localparam logic [CW-1:0] FullCount = CW'(NUM_DIGITS);

    state_e        state_q, state_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [3:0]    op_q, op_d;
    logic          exec_q, exec_d;
    logic          err_q, err_d;

    key_e          key_kind;
    logic [3:0]    digit;
    logic [W+3:0]  shift_full;
    logic [W-1:0]  entry_push;
    logic [W-1:0]  entry_pop;

    assign digit      = key_code[3:0];
    // Oldest digit falls off the top; full entries are rejected before this is used.
    assign shift_full = {entry_q, digit};
    assign entry_push = shift_full[W-1:0];
    assign entry_pop  = entry_q >> 4;

    always_comb begin
        key_kind = KeyNone;
        if (new_key) begin
            if (key_code[4]) begin
                key_kind = (digit <= 4'd9) ? KeyDigit : KeyBadDigit;
            end else begin
                case (digit)
                    4'h1:    key_kind = KeyEqual;
                    4'hE:    key_kind = KeyBack;
                    4'hF:    key_kind = KeyClear;
                    default: key_kind = KeyOp;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        exec_d  = 1'b0;
        err_d   = 1'b0;

        case (key_kind)
            KeyDigit: begin
                if (state_q == StDone) begin
                    entry_d = W'(digit);
                    count_d = (digit != 4'd0) ? CW'(1) : '0;
                    state_d = StEnterA;
                end else if (count_q == '0 && digit == 4'd0) begin
                    // Leading zero: nothing to record.
                end else if (count_q == FullCount) begin
                    err_d = 1'b1;
                end else begin
                    entry_d = entry_push;
                    count_d = count_q + CW'(1);
                end
            end
            KeyBadDigit: err_d = 1'b1;
            KeyEqual: begin
                case (state_q)
                    StEnterA: err_d = 1'b1;
                    StEnterB: begin
                        opb_d   = entry_q;
                        exec_d  = 1'b1;
                        entry_d = '0;
                        count_d = '0;
                        state_d = StDone;
                    end
                    StDone:   exec_d = 1'b1;
                    default:  state_d = StEnterA;
                endcase
            end
            KeyBack: begin
                if (state_q != StDone && count_q != '0) begin
                    entry_d = entry_pop;
                    count_d = count_q - CW'(1);
                end
            end
            KeyClear: begin
                state_d = StEnterA;
                entry_d = '0;
                count_d = '0;
                opa_d   = '0;
                opb_d   = '0;
                op_d    = '0;
            end
            KeyOp: begin
                case (state_q)
                    StEnterA: begin
                        opa_d   = entry_q;
                        op_d    = digit;
                        entry_d = '0;
                        count_d = '0;
                        state_d = StEnterB;
                    end
                    StEnterB: begin
                        // Changing the operator is allowed only before B is started.
                        if (count_q == '0) begin
                            op_d = digit;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    StDone: begin
                        opa_d   = result_in;
                        op_d    = digit;
                        state_d = StEnterB;
                    end
                    default: state_d = StEnterA;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEnterA;
            entry_q <= '0;
            count_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            exec_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            exec_q  <= exec_d;
            err_q   <= err_d;
        end
    end

    assign entry_bcd   = entry_q;
    assign entry_count = count_q;
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign op_code     = op_q;
    assign execute     = exec_q;
    assign key_error   = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: directed scenarios plus random key streams checked
// against a digit-list reference model.
module tb_calc_entry_sequencer;

    localparam int ND = 4;
    localparam int W  = 16;
    localparam int CW = 3;

    localparam logic [4:0] KeyEq  = 5'b00001;
    localparam logic [4:0] KeyBs  = 5'b01110;
    localparam logic [4:0] KeyClr = 5'b01111;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          new_key = 1'b0;
    logic [4:0]    key_code = '0;
    logic [W-1:0]  result_in = '0;
    logic [W-1:0]  entry_bcd;
    logic [CW-1:0] entry_count;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [3:0]    op_code;
    logic          execute;
    logic          key_error;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    calc_entry_sequencer #(.NUM_DIGITS(ND)) dut (
        .clock       (clock),
        .reset       (reset),
        .new_key     (new_key),
        .key_code    (key_code),
        .result_in   (result_in),
        .entry_bcd   (entry_bcd),
        .entry_count (entry_count),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .execute     (execute),
        .key_error   (key_error),
        .state       (state)
    );

    always #5 clock = ~clock;

    // Reference model: entry kept as a list of typed digits, state as 0/1/2.
    logic [3:0]   m_digits[$];
    int           m_state;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_op;
    logic         m_exec, m_err;

    function automatic logic [W-1:0] m_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + int'(m_digits[i]);
        return W'(v);
    endfunction

    function automatic void model_reset();
        m_digits.delete();
        m_state = 0;
        m_a = '0; m_b = '0; m_op = '0;
        m_exec = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_key(input logic [4:0] code, input logic [W-1:0] res);
        logic [3:0] d = code[3:0];
        m_exec = 1'b0;
        m_err  = 1'b0;
        if (code[4]) begin
            if (d > 9) m_err = 1'b1;
            else if (m_state == 2) begin
                m_digits.delete();
                if (d != 0) m_digits.push_back(d);
                m_state = 0;
            end else if (m_digits.size() == 0 && d == 0) begin
            end else if (m_digits.size() == ND) m_err = 1'b1;
            else m_digits.push_back(d);
        end else if (code == KeyEq) begin
            if (m_state == 0) m_err = 1'b1;
            else if (m_state == 1) begin
                m_b = m_value(); m_exec = 1'b1; m_digits.delete(); m_state = 2;
            end else m_exec = 1'b1;
        end else if (code == KeyBs) begin
            if (m_state != 2 && m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (code == KeyClr) begin
            model_reset();
        end else begin
            if (m_state == 0) begin
                m_a = m_value(); m_op = d; m_digits.delete(); m_state = 1;
            end else if (m_state == 1) begin
                if (m_digits.size() == 0) m_op = d;
                else m_err = 1'b1;
            end else begin
                m_a = res; m_op = d; m_state = 1;
            end
        end
    endfunction

    task automatic press(input logic [4:0] code);
        new_key  = 1'b1;
        key_code = code;
        model_key(code, result_in);
        @(posedge clock);
        #1;
        new_key = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        m_exec = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset(input logic with_key, input logic [4:0] code);
        reset    = 1'b1;
        new_key  = with_key;
        key_code = code;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        new_key = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 5'h00);
        n_tests++; if ({entry_bcd, entry_count, operand_a, operand_b, op_code} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h %h want all 0",
                               entry_bcd, entry_count, operand_a, operand_b, op_code); end
        n_tests++; if ({execute, key_error, state} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got exec=%b err=%b state=%b want 0 0 00",
                               execute, key_error, state); end
    endtask

    task automatic test_digit_entry();
        do_reset(1'b0, 5'h00);
        press(5'h11); press(5'h12); press(5'h13);
        n_tests++; if (entry_bcd !== 16'h0123 || entry_count !== 3'd3 || state !== 2'b00) begin
            n_fail++; $display("FAIL digits_123: got %h/%0d/%b want 0123/3/00",
                               entry_bcd, entry_count, state); end
        press(5'h14);
        n_tests++; if (entry_bcd !== 16'h1234 || entry_count !== 3'd4 || key_error !== 1'b0) begin
            n_fail++; $display("FAIL digits_1234: got %h/%0d err=%b want 1234/4 err=0",
                               entry_bcd, entry_count, key_error); end
        press(5'h15);
        n_tests++; if (entry_bcd !== 16'h1234 || entry_count !== 3'd4 || key_error !== 1'b1) begin
            n_fail++; $display("FAIL digits_full: got %h/%0d err=%b want 1234/4 err=1",
                               entry_bcd, entry_count, key_error); end
        idle();
        n_tests++; if (key_error !== 1'b0) begin
            n_fail++; $display("FAIL err_one_cycle: got %b want 0", key_error); end
    endtask

    task automatic test_leading_zero_backspace();
        do_reset(1'b0, 5'h00);
        press(5'h10); press(5'h10); press(5'h17);
        n_tests++; if (entry_bcd !== 16'h0007 || entry_count !== 3'd1 || key_error !== 1'b0) begin
            n_fail++; $display("FAIL lead_zero: got %h/%0d err=%b want 0007/1 err=0",
                               entry_bcd, entry_count, key_error); end
        press(KeyBs);
        n_tests++; if (entry_bcd !== 16'h0 || entry_count !== 3'd0 || key_error !== 1'b0) begin
            n_fail++; $display("FAIL backspace1: got %h/%0d err=%b want 0000/0 err=0",
                               entry_bcd, entry_count, key_error); end
        press(KeyBs);
        n_tests++; if (entry_bcd !== 16'h0 || entry_count !== 3'd0 || key_error !== 1'b0) begin
            n_fail++; $display("FAIL backspace_empty: got %h/%0d err=%b want 0000/0 err=0",
                               entry_bcd, entry_count, key_error); end
    endtask

    task automatic test_calc_repeat();
        do_reset(1'b0, 5'h00);
        press(5'h14); press(5'h02); press(5'h19);
        n_tests++; if (execute !== 1'b0 || state !== 2'b01) begin
            n_fail++; $display("FAIL pre_equal: got exec=%b state=%b want 0 01", execute, state); end
        press(KeyEq);
        n_tests++; if (operand_a !== 16'h0004 || op_code !== 4'h2 || operand_b !== 16'h0009) begin
            n_fail++; $display("FAIL calc_ops: got a=%h op=%h b=%h want 0004 2 0009",
                               operand_a, op_code, operand_b); end
        n_tests++; if (execute !== 1'b1 || state !== 2'b10 || entry_count !== 3'd0) begin
            n_fail++; $display("FAIL calc_exec: got exec=%b state=%b cnt=%0d want 1 10 0",
                               execute, state, entry_count); end
        idle();
        n_tests++; if (execute !== 1'b0) begin
            n_fail++; $display("FAIL exec_one_cycle: got %b want 0", execute); end
        press(KeyEq);
        n_tests++; if (execute !== 1'b1 || operand_a !== 16'h0004 || operand_b !== 16'h0009
                       || op_code !== 4'h2 || state !== 2'b10) begin
            n_fail++; $display("FAIL repeat_equal: got exec=%b a=%h b=%h op=%h st=%b",
                               execute, operand_a, operand_b, op_code, state); end
        idle();
    endtask

    task automatic test_chain();
        result_in = 16'h0013;
        press(5'h03);
        n_tests++; if (operand_a !== 16'h0013 || op_code !== 4'h3 || state !== 2'b01) begin
            n_fail++; $display("FAIL chain_op: got a=%h op=%h st=%b want 0013 3 01",
                               operand_a, op_code, state); end
        result_in = 16'h0000;
        press(5'h12); press(KeyEq);
        n_tests++; if (operand_a !== 16'h0013 || operand_b !== 16'h0002 || execute !== 1'b1) begin
            n_fail++; $display("FAIL chain_exec: got a=%h b=%h exec=%b want 0013 0002 1",
                               operand_a, operand_b, execute); end
        idle();
    endtask

    task automatic test_errors();
        do_reset(1'b0, 5'h00);
        press(KeyEq);
        n_tests++; if (key_error !== 1'b1 || state !== 2'b00 || execute !== 1'b0) begin
            n_fail++; $display("FAIL equal_in_a: got err=%b st=%b exec=%b want 1 00 0",
                               key_error, state, execute); end
        press(5'h13); press(5'b11010);
        n_tests++; if (key_error !== 1'b1 || entry_bcd !== 16'h0003 || entry_count !== 3'd1) begin
            n_fail++; $display("FAIL bad_digit: got err=%b %h/%0d want 1 0003/1",
                               key_error, entry_bcd, entry_count); end
        press(5'h02); press(5'h04);
        n_tests++; if (op_code !== 4'h4 || state !== 2'b01 || key_error !== 1'b0
                       || operand_a !== 16'h0003) begin
            n_fail++; $display("FAIL op_replace: got op=%h st=%b err=%b a=%h want 4 01 0 0003",
                               op_code, state, key_error, operand_a); end
        press(5'h18); press(5'h05);
        n_tests++; if (key_error !== 1'b1 || op_code !== 4'h4 || entry_bcd !== 16'h0008) begin
            n_fail++; $display("FAIL op_mid_b: got err=%b op=%h entry=%h want 1 4 0008",
                               key_error, op_code, entry_bcd); end
    endtask

    task automatic test_reset_clear();
        do_reset(1'b0, 5'h00);
        press(5'h11); press(5'h12); press(5'h02); press(5'h13);
        do_reset(1'b1, 5'h17);
        n_tests++; if ({entry_bcd, entry_count, operand_a, operand_b, op_code, execute,
                        key_error, state} !== '0) begin
            n_fail++; $display("FAIL reset_priority: got %h %0d %h %h %h %b %b %b want all 0",
                               entry_bcd, entry_count, operand_a, operand_b, op_code,
                               execute, key_error, state); end
        press(5'h11); press(5'h12); press(5'h02); press(5'h13); press(KeyClr);
        n_tests++; if ({entry_bcd, entry_count, operand_a, operand_b, op_code, execute,
                        key_error, state} !== '0) begin
            n_fail++; $display("FAIL clear: got %h %0d %h %h %h %b %b %b want all 0",
                               entry_bcd, entry_count, operand_a, operand_b, op_code,
                               execute, key_error, state); end
    endtask

    task automatic test_random();
        logic [4:0]  code;
        logic [58:0] got, want;
        int          r;
        do_reset(1'b0, 5'h00);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      code = {1'b1, 4'($urandom_range(0, 9))};
            else if (r < 55) code = {1'b1, 4'($urandom_range(10, 15))};
            else if (r < 68) code = KeyEq;
            else if (r < 75) code = KeyBs;
            else if (r < 77) code = KeyClr;
            else             code = {1'b0, 4'($urandom_range(0, 15))};
            for (int k = 0; k < ND; k++) result_in[k*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 59) == 0) do_reset(1'b1, code);
            else if ($urandom_range(0, 5) == 0) idle();
            else press(code);
            got  = {entry_bcd, entry_count, operand_a, operand_b, op_code, execute,
                    key_error, state};
            want = {m_value(), CW'(m_digits.size()), m_a, m_b, m_op, m_exec, m_err,
                    2'(m_state)};
            n_tests++; if (got !== want) begin
                n_fail++; $display("FAIL random step %0d key=%b: got %h want %h",
                                   i, code, got, want); end
        end
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_leading_zero_backspace();
        test_calc_repeat();
        test_chain();
        test_errors();
        test_reset_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
